// File: rtl/lcd_hd44780_pkg.sv
// Shared constants, state encoding and DDRAM address helpers for the HD44780 responder.
package lcd_hd44780_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned AC_W       = 7;
  localparam int unsigned DDRAM_SIZE = 80;
  localparam int unsigned CGRAM_SIZE = 64;

  localparam logic [AC_W-1:0] LINE1_END    = 7'h27;
  localparam logic [AC_W-1:0] LINE2_BASE   = 7'h40;
  localparam logic [AC_W-1:0] LINE2_END    = 7'h67;
  localparam logic [AC_W-1:0] LINE2_OFFSET = 7'd40;
  localparam logic [DATA_W-1:0] BLANK      = 8'h20;

  localparam logic [DATA_W-1:0] INS_SET_DDRAM = 8'h80;
  localparam logic [DATA_W-1:0] INS_SET_CGRAM = 8'h40;
  localparam logic [DATA_W-1:0] INS_FUNC_SET  = 8'h20;
  localparam logic [DATA_W-1:0] INS_SHIFT     = 8'h10;
  localparam logic [DATA_W-1:0] INS_DISP_CTRL = 8'h08;
  localparam logic [DATA_W-1:0] INS_ENTRY     = 8'h04;
  localparam logic [DATA_W-1:0] INS_HOME      = 8'h02;
  localparam logic [DATA_W-1:0] INS_CLEAR     = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEARING,
    ST_BUSY
  } state_e;

  function automatic logic ddram_valid(input logic [AC_W-1:0] a);
    return (a <= LINE1_END) || ((a >= LINE2_BASE) && (a <= LINE2_END));
  endfunction

  // Two-line address map folded onto a linear 0..79 storage index.
  function automatic logic [AC_W-1:0] ddram_index(input logic [AC_W-1:0] a);
    return a[6] ? (7'(a[5:0]) + LINE2_OFFSET) : a;
  endfunction

endpackage

// File: rtl/lcd_addr_counter.sv
// Address counter with load and +/-1 step; DDRAM two-line wrap or 6-bit CGRAM wrap.
module lcd_addr_counter
  import lcd_hd44780_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [AC_W-1:0] load_val_i,
  input  logic            step_i,
  input  logic            inc_i,
  input  logic            cgram_i,
  output logic [AC_W-1:0] ac_o
);

  logic [AC_W-1:0] ac_q, ac_d;

  always_comb begin
    ac_d = ac_q;
    if (load_i) begin
      ac_d = load_val_i;
    end else if (step_i) begin
      if (cgram_i) begin
        ac_d = inc_i ? {1'b0, ac_q[5:0] + 6'd1} : {1'b0, ac_q[5:0] - 6'd1};
      end else if (inc_i) begin
        if (ac_q == LINE1_END)      ac_d = LINE2_BASE;
        else if (ac_q == LINE2_END) ac_d = '0;
        else                        ac_d = ac_q + 7'd1;
      end else begin
        if (ac_q == '0)              ac_d = LINE2_END;
        else if (ac_q == LINE2_BASE) ac_d = LINE1_END;
        else                         ac_d = ac_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ac_q <= '0;
    else       ac_q <= ac_d;
  end

  assign ac_o = ac_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible 8-bit bus responder with 80-byte DDRAM, busy timing and error flag.
// Define LCD_RESP_CGRAM_EN to add the 64-byte CGRAM and the set-CGRAM-address instruction.
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 2000,
  parameter int unsigned HOME_CYCLES = 76000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_e,
  input  logic              lcd_rs,
  input  logic              lcd_rw,
  input  logic [DATA_W-1:0] lcd_data_in,
  output logic [DATA_W-1:0] lcd_data_out,
  output logic              lcd_data_oe,
  input  logic [AC_W-1:0]   disp_addr,
  output logic [DATA_W-1:0] disp_char,
  output logic              display_on,
  output logic              cursor_on,
  output logic              blink_on,
  output logic [AC_W-1:0]   addr_counter,
  output logic              busy,
  output logic              protocol_err
);

  logic              e_q, rs_q, rw_q;
  logic [DATA_W-1:0] d_q;
  state_e            state_q, state_d;
  logic [AC_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              id_q, id_d, don_q, don_d, con_q, con_d, bon_q, bon_d;
  logic              err_q, err_d, cg_tgt_q, cg_tgt_d;

  logic              commit, status_rd;
  logic [AC_W-1:0]   ac, ac_load_val;
  logic              ac_load, ac_step, ac_inc;
  logic              ram_we;
  logic [AC_W-1:0]   ram_widx;
  logic [DATA_W-1:0] ram_wdata, ram_rd, rd_data;
  logic [DATA_W-1:0] ddram [DDRAM_SIZE];
`ifdef LCD_RESP_CGRAM_EN
  logic              cg_we;
  logic [DATA_W-1:0] cgram [CGRAM_SIZE];
`endif

  assign commit    = e_q & ~lcd_e & ~reset;
  assign status_rd = ~rs_q & rw_q;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      d_q      <= '0;
      state_q  <= ST_CLEARING;
      fill_q   <= '0;
      cnt_q    <= '0;
      id_q     <= 1'b1;
      don_q    <= 1'b0;
      con_q    <= 1'b0;
      bon_q    <= 1'b0;
      err_q    <= 1'b0;
      cg_tgt_q <= 1'b0;
    end else begin
      e_q      <= lcd_e;
      rs_q     <= lcd_rs;
      rw_q     <= lcd_rw;
      d_q      <= lcd_data_in;
      state_q  <= state_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      don_q    <= don_d;
      con_q    <= con_d;
      bon_q    <= bon_d;
      err_q    <= err_d;
      cg_tgt_q <= cg_tgt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    don_d       = don_q;
    con_d       = con_q;
    bon_d       = bon_q;
    err_d       = err_q;
    cg_tgt_d    = cg_tgt_q;
    ac_load     = 1'b0;
    ac_load_val = '0;
    ac_step     = 1'b0;
    ac_inc      = id_q;
    ram_we      = 1'b0;
    ram_widx    = fill_q;
    ram_wdata   = BLANK;
`ifdef LCD_RESP_CGRAM_EN
    cg_we       = 1'b0;
`endif

    case (state_q)
      ST_CLEARING: begin
        ram_we = 1'b1;
        if (fill_q == 7'(DDRAM_SIZE - 1)) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(HOME_CYCLES - 1);
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    // Bus commits; only IDLE accepts anything other than a status read.
    if (commit && !status_rd) begin
      if (busy) begin
        err_d = 1'b1;
      end else if (rw_q) begin
        ac_step = 1'b1;
      end else if (rs_q) begin
`ifdef LCD_RESP_CGRAM_EN
        cg_we     = cg_tgt_q;
`endif
        ram_we    = ~cg_tgt_q;
        ram_widx  = ddram_index(ac);
        ram_wdata = d_q;
        ac_step   = 1'b1;
        state_d   = ST_BUSY;
        cnt_d     = CNT_W'(BUSY_CYCLES - 1);
      end else if ((d_q & INS_SET_DDRAM) != '0) begin
        if (ddram_valid(d_q[6:0])) begin
          ac_load     = 1'b1;
          ac_load_val = d_q[6:0];
          cg_tgt_d    = 1'b0;
          state_d     = ST_BUSY;
          cnt_d       = CNT_W'(BUSY_CYCLES - 1);
        end else begin
          err_d = 1'b1;
        end
      end else if ((d_q & INS_SET_CGRAM) != '0) begin
`ifdef LCD_RESP_CGRAM_EN
        ac_load     = 1'b1;
        ac_load_val = {1'b0, d_q[5:0]};
        cg_tgt_d    = 1'b1;
        state_d     = ST_BUSY;
        cnt_d       = CNT_W'(BUSY_CYCLES - 1);
`else
        err_d = 1'b1;
`endif
      end else if ((d_q & INS_FUNC_SET) != '0) begin
        if (d_q[4]) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(BUSY_CYCLES - 1);
        end else begin
          err_d = 1'b1;
        end
      end else if ((d_q & INS_SHIFT) != '0) begin
        ac_step = ~d_q[3];
        ac_inc  = d_q[2];
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(BUSY_CYCLES - 1);
      end else if ((d_q & INS_DISP_CTRL) != '0) begin
        don_d   = d_q[2];
        con_d   = d_q[1];
        bon_d   = d_q[0];
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(BUSY_CYCLES - 1);
      end else if ((d_q & INS_ENTRY) != '0) begin
        id_d    = d_q[1];
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(BUSY_CYCLES - 1);
      end else if ((d_q & INS_HOME) != '0) begin
        ac_load  = 1'b1;
        cg_tgt_d = 1'b0;
        state_d  = ST_BUSY;
        cnt_d    = CNT_W'(HOME_CYCLES - 1);
      end else if ((d_q & INS_CLEAR) != '0) begin
        ac_load  = 1'b1;
        id_d     = 1'b1;
        cg_tgt_d = 1'b0;
        state_d  = ST_CLEARING;
        fill_d   = '0;
      end
    end
  end

  lcd_addr_counter u_ac (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ac_load),
    .load_val_i (ac_load_val),
    .step_i     (ac_step),
    .inc_i      (ac_inc),
    .cgram_i    (cg_tgt_q),
    .ac_o       (ac)
  );

  always_ff @(posedge clk) begin
    if (ram_we) ddram[ram_widx] <= ram_wdata;
  end

  assign ram_rd = ddram[ddram_index(ac)];

`ifdef LCD_RESP_CGRAM_EN
  always_ff @(posedge clk) begin
    if (cg_we) cgram[ac[5:0]] <= d_q;
  end
  assign rd_data = cg_tgt_q ? cgram[ac[5:0]] : ram_rd;
`else
  assign rd_data = ram_rd;
`endif

  assign lcd_data_oe  = lcd_e & lcd_rw;
  assign lcd_data_out = !lcd_data_oe ? '0 : (lcd_rs ? rd_data : {busy, ac});
  assign disp_char    = ddram_valid(disp_addr) ? ddram[ddram_index(disp_addr)] : BLANK;
  assign display_on   = don_q;
  assign cursor_on    = con_q;
  assign blink_on     = bon_q;
  assign addr_counter = ac;
  assign protocol_err = err_q;

endmodule
